// File: rtl/prio_encoder_rr_pkg.sv
// Shared constants and helper functions for the priority encoder.
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of an index able to address n request lines; never below 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Pointer position after a round-robin win: the winner becomes the
  // lowest priority, and index 0 wraps back up to n-1.
  function automatic int next_ptr(input int winner, input int n);
    return (winner == 0) ? (n - 1) : (winner - 1);
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/response bundle between request sources, the encoder and its consumer.
interface prio_encoder_rr_if #(
  parameter int N = 8
) ();
  import prio_pkg::*;

  localparam int W = clog2(N);

  logic [N-1:0] req;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] code;
  logic [N-1:0] grant;
  logic         any;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  req, mode, in_valid, out_ready,
    output in_ready, code, grant, any, out_valid
  );

  modport master (
    output req, mode, in_valid, out_ready,
    input  in_ready, code, grant, any, out_valid
  );

endinterface

// File: rtl/prio_encoder_rr_scan.sv
// Combinational winner search: rotate the request vector so the start index
// sits at the top, find the highest set bit, then map it back.
module prio_scan
  import prio_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] winner_o,
  output logic [N-1:0] onehot_o,
  output logic         any_o
);

  logic [N-1:0] rot;
  logic [W-1:0] hitPos;
  logic         found;

  // Rotated position k maps to original index (start + k + 1) mod N, so the
  // top rotated bit is the start index and lower bits descend with wrap.
  function automatic logic [W-1:0] unrotate(input logic [W-1:0] s, input int k);
    int idx;
    idx = int'(s) + k + 1;
    if (idx >= N) begin
      idx = idx - N;
    end
    return W'(idx);
  endfunction

  // Build the rotated request vector.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req_i[unrotate(start_i, k)];
    end
  end

  // Highest set bit in the rotated frame; later hits overwrite earlier ones.
  always_comb begin
    found  = 1'b0;
    hitPos = '0;
    for (int k = 0; k < N; k++) begin
      if (rot[k]) begin
        found  = 1'b1;
        hitPos = W'(k);
      end
    end
  end

  // Map the hit back to a real index and form the one-hot grant.
  always_comb begin
    any_o    = found;
    winner_o = '0;
    onehot_o = '0;
    if (found) begin
      winner_o           = unrotate(start_i, int'(hitPos));
      onehot_o[winner_o] = 1'b1;
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Priority encoder with fixed or round-robin arbitration, a registered result
// and valid/ready handshakes on both sides.
module prio_encoder_rr
  import prio_pkg::*;
#(
  parameter int N = 8
) (
  input logic          clk,
  input logic          rst,
  prio_encoder_rr_if.slave bus
);

  localparam int W = clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic         outValid_q, outValid_d;
  logic [W-1:0] code_q, code_d;
  logic [N-1:0] grant_q, grant_d;
  logic         any_q, any_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic [W-1:0] scanStart;
  logic [W-1:0] scanWinner;
  logic [N-1:0] scanOneHot;
  logic         scanAny;

  assign bus.in_ready = !outValid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign scanStart    = (bus.mode == MODE_FIXED) ? LAST : ptr_q;

  prio_scan #(
    .N(N),
    .W(W)
  ) u_scan (
    .req_i    (bus.req),
    .start_i  (scanStart),
    .winner_o (scanWinner),
    .onehot_o (scanOneHot),
    .any_o    (scanAny)
  );

  // Load a new result on accept, drop valid after a bare handshake, else hold;
  // the pointer only moves on a round-robin beat that actually had a winner.
  always_comb begin
    outValid_d = outValid_q;
    code_d     = code_q;
    grant_d    = grant_q;
    any_d      = any_q;
    ptr_d      = ptr_q;
    if (accept) begin
      outValid_d = 1'b1;
      code_d     = scanWinner;
      grant_d    = scanOneHot;
      any_d      = scanAny;
      if ((bus.mode == MODE_RR) && scanAny) begin
        ptr_d = W'(next_ptr(int'(scanWinner), N));
      end
    end else if (bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers; reset wins over any simultaneous accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      code_q     <= '0;
      grant_q    <= '0;
      any_q      <= 1'b0;
      ptr_q      <= LAST;
    end else begin
      outValid_q <= outValid_d;
      code_q     <= code_d;
      grant_q    <= grant_d;
      any_q      <= any_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.code      = code_q;
  assign bus.grant     = grant_q;
  assign bus.any       = any_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr at N=8 and N=5.
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  typedef struct {
    int         code;
    logic [7:0] grant;
    logic       any;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   total = 0;
  int   bad   = 0;
  int   ptr8  = 7;
  int   ptr5  = 4;
  int   bpMode = 0;

  prio_encoder_rr_if #(.N(8)) bus8 ();
  prio_encoder_rr_if #(.N(5)) bus5 ();

  prio_encoder_rr #(.N(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  // One comparison, counted; a mismatch prints a single FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arbitration: walk downwards from the start index with wrap,
  // first requester found wins; round-robin wins push the pointer below it.
  function automatic exp_t refModel(input logic [7:0] r, input int n, input logic m, inout int ptr);
    exp_t e;
    int   start;
    int   idx;
    e.code  = 0;
    e.grant = '0;
    e.any   = 1'b0;
    start   = m ? ptr : n - 1;
    for (int j = 0; j < n; j++) begin
      idx = (start - j + n) % n;
      if ((((r >> idx) & 8'd1) != 8'd0) && !e.any) begin
        e.any  = 1'b1;
        e.code = idx;
      end
    end
    if (e.any) begin
      e.grant = 8'd1 << e.code;
      if (m) begin
        ptr = (e.code == 0) ? n - 1 : e.code - 1;
      end
    end
    return e;
  endfunction

  // Consumer readiness for the N=8 instance: always, random, or stalled.
  always @(posedge clk) begin
    #2;
    case (bpMode)
      0:       bus8.out_ready = 1'b1;
      1:       bus8.out_ready = ($urandom_range(0, 3) != 0);
      default: bus8.out_ready = 1'b0;
    endcase
  end

  // Monitor for N=8: every handshake pops and checks the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        checkOutput("sb8_pop", 32'(q8.size()), 32'd1);
      end else begin
        e = q8.pop_front();
        checkOutput("code8", 32'(bus8.code), 32'(e.code));
        checkOutput("grant8", 32'(bus8.grant), 32'(e.grant));
        checkOutput("any8", 32'(bus8.any), 32'(e.any));
      end
    end
  end

  // Monitor for N=5.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus5.out_valid && bus5.out_ready) begin
      if (q5.size() == 0) begin
        checkOutput("sb5_pop", 32'(q5.size()), 32'd1);
      end else begin
        e = q5.pop_front();
        checkOutput("code5", 32'(bus5.code), 32'(e.code));
        checkOutput("grant5", 32'(bus5.grant), 32'(e.grant[4:0]));
        checkOutput("any5", 32'(bus5.any), 32'(e.any));
      end
    end
  end

  // Offer one beat to the N=8 instance, waiting (bounded) for in_ready.
  task automatic applyStimulus(input logic [7:0] r, input logic m);
    int   t;
    exp_t e;
    bus8.req      = r;
    bus8.mode     = m;
    bus8.in_valid = 1'b1;
    t = 0;
    while (!bus8.in_ready && t < 100) begin
      @(negedge clk);
      t = t + 1;
    end
    if (!bus8.in_ready) begin
      checkOutput("accept_timeout8", 32'(bus8.in_ready), 32'd1);
    end else begin
      e = refModel(r, 8, m, ptr8);
      q8.push_back(e);
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  // Offer one beat to the N=5 instance; its consumer is always ready.
  task automatic applyStimulus5(input logic [4:0] r, input logic m);
    int   t;
    exp_t e;
    bus5.req      = r;
    bus5.mode     = m;
    bus5.in_valid = 1'b1;
    t = 0;
    while (!bus5.in_ready && t < 100) begin
      @(negedge clk);
      t = t + 1;
    end
    if (!bus5.in_ready) begin
      checkOutput("accept_timeout5", 32'(bus5.in_ready), 32'd1);
    end else begin
      e = refModel({3'b000, r}, 5, m, ptr5);
      q5.push_back(e);
    end
    @(negedge clk);
    bus5.in_valid = 1'b0;
  endtask

  // Synchronous reset pulse, model reset, and reset-state checks.
  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    bus8.in_valid = 1'b0;
    bus5.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q8.delete();
    q5.delete();
    ptr8 = 7;
    ptr5 = 4;
    checkOutput("rst_out_valid8", 32'(bus8.out_valid), 32'd0);
    checkOutput("rst_code8", 32'(bus8.code), 32'd0);
    checkOutput("rst_grant8", 32'(bus8.grant), 32'd0);
    checkOutput("rst_any8", 32'(bus8.any), 32'd0);
    checkOutput("rst_in_ready8", 32'(bus8.in_ready), 32'd1);
    checkOutput("rst_out_valid5", 32'(bus5.out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    logic       m;
    int         t;

    bus8.req       = '0;
    bus8.mode      = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    bus5.req       = '0;
    bus5.mode      = 1'b0;
    bus5.in_valid  = 1'b0;
    bus5.out_ready = 1'b1;

    doReset();

    // Non-power-of-two wrap: 4,0,4,0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus5(5'b10001, 1'b1);
    end

    // Fixed-priority example, then the full 8-to-3 truth table.
    applyStimulus(8'b0010_0110, 1'b0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i), 1'b0);
    end

    // Round-robin on all-ones: 7,6,5,4 then 3 from the retained pointer.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'hFF, 1'b1);
    end

    // Round-robin wrap at N=8: 7,0,7,0.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'b1000_0001, 1'b1);
    end

    // Backpressure: result frozen, new request ignored while stalled.
    doReset();
    bpMode = 2;
    @(negedge clk);
    applyStimulus(8'b0100_1000, 1'b1);
    bus8.req      = 8'hFF;
    bus8.mode     = 1'b1;
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_in_ready", 32'(bus8.in_ready), 32'd0);
      checkOutput("stall_out_valid", 32'(bus8.out_valid), 32'd1);
      checkOutput("stall_code", 32'(bus8.code), 32'd6);
      checkOutput("stall_grant", 32'(bus8.grant), 32'h40);
      checkOutput("stall_any", 32'(bus8.any), 32'd1);
      @(negedge clk);
    end
    bus8.in_valid = 1'b0;
    bpMode = 0;
    applyStimulus(8'hFF, 1'b1);

    // Reset while a result is pending and a beat is offered.
    bpMode = 2;
    @(negedge clk);
    @(negedge clk);
    applyStimulus(8'h0F, 1'b1);
    bus8.req      = 8'h0F;
    bus8.mode     = 1'b1;
    bus8.in_valid = 1'b1;
    rst           = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("midrst_grant", 32'(bus8.grant), 32'd0);
    checkOutput("midrst_code", 32'(bus8.code), 32'd0);
    checkOutput("midrst_any", 32'(bus8.any), 32'd0);
    rst           = 1'b0;
    bus8.in_valid = 1'b0;
    q8.delete();
    q5.delete();
    ptr8   = 7;
    ptr5   = 4;
    bpMode = 0;
    applyStimulus(8'hFF, 1'b1);

    // Random traffic with random backpressure and mode switching.
    bpMode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
      end
      r = 8'($urandom);
      case ($urandom_range(0, 5))
        0:       r = 8'h00;
        1:       r = r & 8'($urandom);
        default: ;
      endcase
      m = 1'($urandom_range(0, 1));
      applyStimulus(r, m);
    end

    // Random beats on the non-power-of-two instance.
    for (int i = 0; i < 60; i++) begin
      applyStimulus5(5'($urandom), 1'($urandom_range(0, 1)));
    end

    // Let outstanding results drain.
    bpMode = 0;
    t = 0;
    while ((q8.size() != 0 || q5.size() != 0) && t < 50) begin
      @(negedge clk);
      t = t + 1;
    end
    checkOutput("drain8", 32'(q8.size()), 32'd0);
    checkOutput("drain5", 32'(q5.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised N-to-log2(N) priority encoder with a registered output and a valid/ready handshake on both sides.
- Fixed mode: the highest set index wins, so N=8 reproduces the classic 8-to-3 encoder truth table, including the valid flag.
- Round-robin mode: a rotating priority pointer gives fair arbitration among requesters.
- Sits between request sources and downstream consumers (interrupt or bus arbitration) that need an encoded winner plus a one-hot grant.

Parameters:
- N, 8, number of request lines; N >= 2; need not be a power of two.
- W, $clog2(N), width of the encoded index (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request vector; bit i = requester i.
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled with each accepted beat.
- in_valid  input  1  req/mode are valid this cycle.
- in_ready  output  1  block can accept a beat this cycle.
- code  output  W  encoded winning index.
- grant  output  N  one-hot winner; all-zero when no request.
- any  output  1  at least one req bit was set (V flag).
- out_valid  output  1  code/grant/any hold a result.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Values on reset:
  - out_valid=0, code=0, grant=0, any=0.
  - Internal pointer ptr=N-1.
  - in_ready=1 on the cycle after reset.
- Accept condition: a beat is accepted when in_valid && in_ready.
- Ready rule: in_ready = !out_valid || out_ready. This is combinational; back-to-back accept at one beat per clock is allowed.
- Latency: result registered exactly 1 cycle after accept; out_valid rises on that edge.
- Output hold: out_valid, code, grant and any hold stable while out_valid && !out_ready.
- Output drop: out_valid falls after a handshake only if no new beat was accepted the same cycle.
- Fixed mode (mode=0):
  - Winner = highest i with req[i]=1.
  - ptr is not modified.
- Round-robin mode (mode=1):
  - Search starts at index ptr and descends, wrapping from 0 to N-1. The first set bit wins.
  - On an accepted beat with any=1: ptr <= (winner==0) ? N-1 : winner-1. The winner becomes lowest priority next time.
  - Because of the wrap rule, a non-power-of-two N never yields ptr >= N.
- Zero vector (req=0):
  - A beat is still produced with any=0, code=0, grant=0.
  - ptr is unchanged in either mode.
- Mode switch: takes effect on the beat it arrives with. Switching back to round-robin resumes from the retained ptr.
- Backpressure: no accept means no ptr update. req is ignored while in_ready=0, so the upstream must hold.
- Reset mid-operation: a pending output is discarded and all state returns to reset values on the next edge. Reset overrides a simultaneous accept.
- Invariants:
  - grant == (any ? 1<<code : 0).
  - At most one grant bit is set.
  - any == |req of the accepted beat.

Decomposition:
- Shared package prio_pkg:
  - constants MODE_FIXED=1'b0, MODE_RR=1'b1;
  - function clog2 for W;
  - function next_ptr(winner, N).
- One sub-module, prio_scan (combinational):
  - inputs: req, start index.
  - outputs: winner index, one-hot, any.
  - implemented as rotate-by-start → highest-set-bit find → un-rotate.
  - fixed mode drives start=N-1.
- The top level holds the handshake, output register and ptr register.

Test Plan:
1. N=8, mode=0, req=8'b0010_0110, out_ready=1 → next cycle out_valid=1, code=5, grant=8'b0010_0000, any=1.
2. N=8, mode=0, req=8'h00 → code=0, grant=0, any=0, out_valid=1; sweep all 256 vectors against the 8-to-3 truth table.
3. N=8, mode=1, req=8'hFF for 4 consecutive beats after reset → codes 7,6,5,4; ptr ends at 3.
4. N=8, mode=1, req=8'b1000_0001 repeated → codes 7,0,7,0 (wrap from 0 back to N-1). Repeat with N=5, req=5'b10001 → 4,0,4,0.
5. out_ready=0 for 3 cycles with out_valid=1 → in_ready=0, outputs frozen, ptr unchanged, new req ignored. Raising out_ready gives one handshake, then the next accepted result appears 1 cycle later.
6. rst asserted while out_valid=1 and in_valid=1 → next cycle out_valid=0, grant=0. The first round-robin beat with req=8'hFF then yields code=7.
